// File: rtl/tile_scheduler.sv
// Tile scheduler: walks an M x N_t output grid with K partial products per output tile,
// issuing one systolic-array tile matmul at a time and waiting for each to complete.
//
// state   | meaning
// IDLE    | ready for a job request
// ISSUE   | tile_start pulse with current tile addresses
// WAIT    | tile in flight, waiting for tile_done
// ADVANCE | step k (inner), n (middle), m (outer) indices
// FINISH  | job_done pulse, then back to IDLE
module tile_scheduler #(
   parameter int N  = 4,
   parameter int TW = 8
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [31:0]     cfg_x_base,
   input  logic [31:0]     cfg_w_base,
   input  logic [31:0]     cfg_o_base,
   input  logic [TW-1:0]   cfg_m_tiles,
   input  logic [TW-1:0]   cfg_k_tiles,
   input  logic [TW-1:0]   cfg_n_tiles,
   input  logic            abort,
   output logic            tile_start,
   output logic [31:0]     tile_x_addr,
   output logic [31:0]     tile_w_addr,
   output logic [31:0]     tile_o_addr,
   output logic            tile_accum,
   input  logic            tile_done,
   output logic            busy,
   output logic            job_done,
   output logic            job_aborted,
   output logic [3*TW-1:0] tiles_issued
);

   localparam logic [31:0] TILE_WORDS = 32'(N * N);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, ADVANCE, FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         x_base_q, x_base_d, w_base_q, w_base_d, o_base_q, o_base_d;
   logic [TW-1:0]       m_tiles_q, m_tiles_d, k_tiles_q, k_tiles_d, n_tiles_q, n_tiles_d;
   logic [TW-1:0]       m_q, m_d, n_q, n_d, k_q, k_d;
   logic [31:0]         x_addr_q, x_addr_d, w_addr_q, w_addr_d, o_addr_q, o_addr_d;
   logic                accum_q, accum_d;
   logic                aborted_q, aborted_d;
   logic [3*TW-1:0]     issued_q, issued_d;
   logic                k_last, n_last, m_last;

   // Linear tile index scaled to words, wrapping modulo 2^32.
   function automatic logic [31:0] tile_addr(input logic [31:0] base, input logic [TW-1:0] row,
                                             input logic [TW-1:0] cols, input logic [TW-1:0] col);
      return base + (32'(row) * 32'(cols) + 32'(col)) * TILE_WORDS;
   endfunction

   always_comb begin
      state_d   = state_q;
      x_base_d  = x_base_q;
      w_base_d  = w_base_q;
      o_base_d  = o_base_q;
      m_tiles_d = m_tiles_q;
      k_tiles_d = k_tiles_q;
      n_tiles_d = n_tiles_q;
      m_d       = m_q;
      n_d       = n_q;
      k_d       = k_q;
      x_addr_d  = x_addr_q;
      w_addr_d  = w_addr_q;
      o_addr_d  = o_addr_q;
      accum_d   = accum_q;
      aborted_d = aborted_q;
      issued_d  = issued_q;
      k_last    = (k_q == k_tiles_q - 1'b1);
      n_last    = (n_q == n_tiles_q - 1'b1);
      m_last    = (m_q == m_tiles_q - 1'b1);

      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               x_base_d  = cfg_x_base;
               w_base_d  = cfg_w_base;
               o_base_d  = cfg_o_base;
               m_tiles_d = cfg_m_tiles;
               k_tiles_d = cfg_k_tiles;
               n_tiles_d = cfg_n_tiles;
               m_d       = '0;
               n_d       = '0;
               k_d       = '0;
               issued_d  = '0;
               aborted_d = 1'b0;
               if (cfg_m_tiles == '0 || cfg_k_tiles == '0 || cfg_n_tiles == '0) begin
                  state_d = FINISH;
               end else begin
                  // All indices are zero for the first tile, so addresses are the bases.
                  x_addr_d = cfg_x_base;
                  w_addr_d = cfg_w_base;
                  o_addr_d = cfg_o_base;
                  accum_d  = 1'b0;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            issued_d = issued_q + 1'b1;
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = FINISH;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = FINISH;
            end else if (tile_done) begin
               state_d = ADVANCE;
            end
         end
         ADVANCE: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = FINISH;
            end else if (k_last && n_last && m_last) begin
               state_d = FINISH;
            end else begin
               if (!k_last) begin
                  k_d = k_q + 1'b1;
               end else begin
                  k_d = '0;
                  if (!n_last) begin
                     n_d = n_q + 1'b1;
                  end else begin
                     n_d = '0;
                     m_d = m_q + 1'b1;
                  end
               end
               x_addr_d = tile_addr(x_base_q, m_d, k_tiles_q, k_d);
               w_addr_d = tile_addr(w_base_q, k_d, n_tiles_q, n_d);
               o_addr_d = tile_addr(o_base_q, m_d, n_tiles_q, n_d);
               accum_d  = (k_d != '0);
               state_d  = ISSUE;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q   <= IDLE;
         x_base_q  <= '0;
         w_base_q  <= '0;
         o_base_q  <= '0;
         m_tiles_q <= '0;
         k_tiles_q <= '0;
         n_tiles_q <= '0;
         m_q       <= '0;
         n_q       <= '0;
         k_q       <= '0;
         x_addr_q  <= '0;
         w_addr_q  <= '0;
         o_addr_q  <= '0;
         accum_q   <= 1'b0;
         aborted_q <= 1'b0;
         issued_q  <= '0;
      end else begin
         state_q   <= state_d;
         x_base_q  <= x_base_d;
         w_base_q  <= w_base_d;
         o_base_q  <= o_base_d;
         m_tiles_q <= m_tiles_d;
         k_tiles_q <= k_tiles_d;
         n_tiles_q <= n_tiles_d;
         m_q       <= m_d;
         n_q       <= n_d;
         k_q       <= k_d;
         x_addr_q  <= x_addr_d;
         w_addr_q  <= w_addr_d;
         o_addr_q  <= o_addr_d;
         accum_q   <= accum_d;
         aborted_q <= aborted_d;
         issued_q  <= issued_d;
      end
   end

   assign cfg_ready    = (state_q == IDLE);
   assign busy         = (state_q == ISSUE) || (state_q == WAIT) || (state_q == ADVANCE);
   assign tile_start   = (state_q == ISSUE);
   assign job_done     = (state_q == FINISH);
   assign job_aborted  = aborted_q;
   assign tile_x_addr  = x_addr_q;
   assign tile_w_addr  = w_addr_q;
   assign tile_o_addr  = o_addr_q;
   assign tile_accum   = accum_q;
   assign tiles_issued = issued_q;

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter N, default 4, meaning systolic array dimension; one tile is N x N words.
REQ-002 SHALL have parameter TW, default 8, meaning width of each tile-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst  input  1  synchronous reset, active-high (asserted = 1), sampled on clk.
REQ-005 SHALL have port cfg_valid  input  1  job request qualifier.
REQ-006 SHALL have port cfg_ready  output  1  job request accepted when cfg_valid and cfg_ready are both 1.
REQ-007 SHALL have ports cfg_x_base, cfg_w_base, cfg_o_base  input  32 each  word base addresses of input, weight and output matrices.
REQ-008 SHALL have ports cfg_m_tiles, cfg_k_tiles, cfg_n_tiles  input  TW each  matrix size in tiles (X is M x K tiles, W is K x N tiles, O is M x N tiles).
REQ-009 SHALL have port abort  input  1  terminate current job.
REQ-010 SHALL have port tile_start  output  1  one-cycle pulse launching one tile matmul.
REQ-011 SHALL have ports tile_x_addr, tile_w_addr, tile_o_addr  output  32 each  tile addresses, valid while tile_start = 1 and held until the next tile_start.
REQ-012 SHALL have port tile_accum  output  1  1 = accumulate into existing output tile (k index > 0).
REQ-013 SHALL have port tile_done  input  1  one-cycle pulse from the array when the launched tile completes.
REQ-014 SHALL have port busy  output  1  job in progress.
REQ-015 SHALL have port job_done  output  1  one-cycle pulse at job end (normal or aborted).
REQ-016 SHALL have port job_aborted  output  1  qualifies job_done; 1 = job ended by abort.
REQ-017 SHALL have port tiles_issued  output  3*TW  count of tile_start pulses in the current or last job.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, ADVANCE, FINISH.
REQ-019 IDLE: cfg_ready = 1 and busy = 0; on handshake, SHALL latch all cfg_* inputs, clear the m/n/k indices and tiles_issued, and go to ISSUE, or go to FINISH if any tile count is 0.
REQ-020 ISSUE: SHALL assert tile_start for exactly one cycle with the current addresses, increment tiles_issued, and go to WAIT.
REQ-021 WAIT: SHALL hold until tile_done = 1, then go to ADVANCE; tile_done in any other state SHALL be ignored.
REQ-022 ADVANCE: SHALL step the loops with k innermost, n middle and m outermost; go to ISSUE if tiles remain, otherwise FINISH; one cycle.
REQ-023 FINISH: SHALL pulse job_done for one cycle and return to IDLE; cfg_ready = 0 in FINISH.
REQ-024 Addresses SHALL use S = N*N: tile_x_addr = x_base + (m*K + k)*S, tile_w_addr = w_base + (k*N_t + n)*S, tile_o_addr = o_base + (m*N_t + n)*S, where N_t = cfg_n_tiles; all sums are modulo 2^32.
REQ-025 tile_accum SHALL be 1 exactly when k != 0 for the issued tile.
REQ-026 Latency: tile_start SHALL occur 1 cycle after cfg handshake, and 2 cycles after each tile_done (ADVANCE, then ISSUE); job_done SHALL occur 2 cycles after the final tile_done.
REQ-027 busy SHALL be 1 in ISSUE, WAIT and ADVANCE, and 0 in IDLE and FINISH.
REQ-028 abort SHALL take effect only while busy = 1: next state FINISH with job_aborted = 1; no further tile_start; tiles_issued frozen. abort in IDLE or FINISH SHALL be ignored.
REQ-029 If abort and tile_done are both 1 in WAIT, abort SHALL win.
REQ-030 cfg_valid while busy SHALL not be accepted; cfg_* changes after the handshake SHALL not affect the running job.
REQ-031 Job with a zero tile count: job_done SHALL occur 1 cycle after the handshake, with tiles_issued = 0 and job_aborted = 0.

Reset
REQ-032 While n_rst = 1, the block SHALL enter IDLE on the next clk edge and clear tile_start, tile_accum, busy, job_done, job_aborted, tiles_issued and all tile addresses to 0; cfg_ready SHALL be 1 after reset.
REQ-033 Reset mid-job SHALL discard the job with no job_done pulse; a tile_done arriving after reset SHALL be ignored.

Verification
REQ-034 M=K=N_t=1, bases 0x100/0x200/0x300, N=4 -> one tile_start with x=0x100, w=0x200, o=0x300, accum=0; tile_done -> job_done 2 cycles later, tiles_issued=1.
REQ-035 M=2, K=2, N_t=1, bases 0 -> 4 tiles in order (x,w,o,accum) = (0,0,0,0), (16,16,0,1), (32,0,16,0), (48,16,16,1).
REQ-036 K=0 -> job_done 1 cycle after handshake, no tile_start, job_aborted=0.
REQ-037 abort asserted in the same cycle as tile_done for tile 2 of 8 -> no further tile_start, job_done with job_aborted=1, tiles_issued=2.
REQ-038 x_base=0xFFFF_FFF0, K=2 -> second tile x address = 0x0000_0000 (wrap).
REQ-039 n_rst pulsed during WAIT, then a late tile_done -> IDLE, cfg_ready=1, no job_done, late tile_done ignored; a new job runs normally afterwards.
